// File: rtl/fir_seq_ctrl_if.sv
// Command, data and filter-result handshake bundle between a sequencer
// (master side) and the fir_seq_ctrl controller (slave side).
interface fir_seq_ctrl_if #(
  parameter int NUM_COEFF = 4,
  parameter int SIZE      = 8
) ();
  logic                      cmd_valid;
  logic [1:0]                cmd_op;
  logic                      cmd_ready;
  logic [SIZE-1:0]           data_in;
  logic                      data_valid;
  logic                      data_ready;
  logic [NUM_COEFF*SIZE-1:0] coeffs;
  logic                      sr_en;
  logic                      sr_clear;
  logic [SIZE-1:0]           y_in;
  logic [SIZE-1:0]           y_out;
  logic                      y_valid;
  logic [1:0]                state;
  logic                      cmd_err;

  modport master (
    output cmd_valid, cmd_op, data_in, data_valid, y_in,
    input  cmd_ready, data_ready, coeffs, sr_en, sr_clear, y_out, y_valid,
           state, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, data_in, data_valid, y_in,
    output cmd_ready, data_ready, coeffs, sr_en, sr_clear, y_out, y_valid,
           state, cmd_err
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: atomic coefficient loading, shift-register priming and
// result strobing. Define FIR_SEQ_CTRL_CMD_ERR_EN to enable sticky illegal-command detection.
module fir_seq_ctrl #(
  parameter int NUM_COEFF = 4,
  parameter int SIZE      = 8
) (
  input  logic           clk,
  input  logic           reset,
  fir_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PRIME = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_RUN  = 2'd2,
    OP_STOP = 2'd3
  } op_e;

  localparam int CNT_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NUM_COEFF - 1);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'((NUM_COEFF >= 2) ? NUM_COEFF - 2 : 0);

  typedef logic [NUM_COEFF-1:0][SIZE-1:0] coeff_t;

  function automatic coeff_t default_coeffs();
    coeff_t c;
    for (int i = 0; i < NUM_COEFF; i++) c[i] = SIZE'(i + 1);
    return c;
  endfunction

  localparam coeff_t COEFF_RST = default_coeffs();

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coeff_t           shadow_q, shadow_d;
  coeff_t           coeffs_q, coeffs_d;
  logic             pend_q, pend_d;
  logic [SIZE-1:0]  y_out_q, y_out_d;
  logic             y_valid_q, y_valid_d;

  logic cmd_ready, data_ready, cmd_acc, data_acc, sr_en, sr_clear;
  op_e  op;

  assign op       = op_e'(bus.cmd_op);
  assign cmd_acc  = bus.cmd_valid & cmd_ready;
  assign data_acc = bus.data_valid & data_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc && op == OP_LOAD) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (cmd_acc && op == OP_RUN) begin
          state_d = (NUM_COEFF == 1) ? S_RUN : S_PRIME;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (data_acc) begin
          if (cnt_q == LOAD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PRIME: begin
        if (data_acc) begin
          if (cnt_q == PRIME_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // STOP wins over a simultaneous final priming sample.
        if (cmd_acc && op == OP_STOP) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cmd_acc && op == OP_STOP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so a beat or command coinciding with reset has no effect.
  always_comb begin
    cmd_ready  = (state_q != S_LOAD);
    data_ready = (state_q != S_IDLE);
    sr_en      = !reset && (state_q == S_PRIME || state_q == S_RUN) && data_acc;
    sr_clear   = !reset && (state_q == S_IDLE) && cmd_acc && (op == OP_RUN);
  end

  always_comb begin
    shadow_d  = shadow_q;
    coeffs_d  = coeffs_q;
    pend_d    = (state_q == S_RUN) && data_acc;
    y_valid_d = pend_q;
    y_out_d   = pend_q ? bus.y_in : y_out_q;
    if (state_q == S_LOAD && data_acc) begin
      shadow_d[cnt_q] = bus.data_in;
      // Commit the whole set at once, including the beat arriving now.
      if (cnt_q == LOAD_LAST) coeffs_d = shadow_d;
    end
  end

  // NOTE: the shadow and coefficient arrays are reset to defined defaults because the
  // filter consumes coeffs immediately after reset; plain storage arrays would not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      shadow_q  <= COEFF_RST;
      coeffs_q  <= COEFF_RST;
      pend_q    <= 1'b0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      coeffs_q  <= coeffs_d;
      pend_q    <= pend_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

`ifdef FIR_SEQ_CTRL_CMD_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (cmd_acc) begin
      if ((state_q == S_PRIME || state_q == S_RUN) && (op == OP_LOAD || op == OP_RUN))
        err_d = 1'b1;
      if (state_q == S_IDLE && op == OP_STOP)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.cmd_err = err_q;
`else
  assign bus.cmd_err = 1'b0;
`endif

  assign bus.cmd_ready  = cmd_ready;
  assign bus.data_ready = data_ready;
  assign bus.sr_en      = sr_en;
  assign bus.sr_clear   = sr_clear;
  assign bus.coeffs     = coeffs_q;
  assign bus.y_out      = y_out_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with an external 4-tap shift-register/MAC model
// producing y_in from the committed coefficients.
module tb_fir_seq_ctrl;

  localparam int NC = 4;
  localparam int SZ = 8;

`ifdef FIR_SEQ_CTRL_CMD_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fir_seq_ctrl_if #(.NUM_COEFF(NC), .SIZE(SZ)) bus ();

  fir_seq_ctrl #(.NUM_COEFF(NC), .SIZE(SZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External filter: sr[0] holds the newest sample.
  logic [SZ-1:0] sr [NC];

  always @(posedge clk) begin
    if (reset || bus.sr_clear) begin
      for (int i = 0; i < NC; i++) sr[i] <= '0;
    end else if (bus.sr_en) begin
      sr[0] <= bus.data_in;
      for (int i = 1; i < NC; i++) sr[i] <= sr[i-1];
    end
  end

  always_comb begin
    logic [SZ-1:0] acc;
    acc = '0;
    for (int i = 0; i < NC; i++) acc = acc + SZ'(bus.coeffs[i*SZ +: SZ] * sr[i]);
    bus.y_in = acc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
  endtask

  task automatic send_beat(input logic [SZ-1:0] v);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  logic [6:0]    yv_exp;
  logic [SZ-1:0] ld_vals [NC];

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_coeffs", bus.coeffs, 32'h04030201);
    check("rst_state", {30'd0, bus.state}, 32'd0);
    check("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    check("rst_y_out", {24'd0, bus.y_out}, 32'd0);
    check("rst_cmd_err", {31'd0, bus.cmd_err}, 32'd0);
    check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("idle_data_ready", {31'd0, bus.data_ready}, 32'd0);

    // Atomic coefficient load 5,6,7,8
    send_cmd(2'b01);
    check("load_state", {30'd0, bus.state}, 32'd1);
    check("load_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("load_data_ready", {31'd0, bus.data_ready}, 32'd1);
    ld_vals = '{8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < NC; i++) begin
      send_beat(ld_vals[i]);
      check($sformatf("load_coeffs_b%0d", i), bus.coeffs,
            (i == NC - 1) ? 32'h08070605 : 32'h04030201);
    end
    check("load_done_state", {30'd0, bus.state}, 32'd0);

    // RUN: clear pulse, priming without results, then 26 = 5+6+7+8 on samples 4 and 5
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    #1;
    check("run_sr_clear", {31'd0, bus.sr_clear}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    check("run_sr_clear_gone", {31'd0, bus.sr_clear}, 32'd0);
    check("prime_state", {30'd0, bus.state}, 32'd2);
    yv_exp = 7'b0110000;
    for (int t = 0; t < 7; t++) begin
      bus.data_in    = 8'd1;
      bus.data_valid = (t < 5);
      #1;
      if (t < 5) check($sformatf("sr_en_s%0d", t), {31'd0, bus.sr_en}, 32'd1);
      tick();
      check($sformatf("y_valid_t%0d", t), {31'd0, bus.y_valid}, {31'd0, yv_exp[t]});
      if (t == 2) check("run_state", {30'd0, bus.state}, 32'd3);
      if (t >= 4) check($sformatf("y_out_t%0d", t), {24'd0, bus.y_out}, 32'd26);
    end
    bus.data_valid = 1'b0;

    // STOP with a sample in the same cycle: 5*2+6+7+8 = 31 still emerges
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'b11;
    bus.data_in    = 8'd2;
    bus.data_valid = 1'b1;
    #1;
    check("stop_sr_en", {31'd0, bus.sr_en}, 32'd1);
    tick();
    bus.cmd_valid  = 1'b0;
    bus.data_valid = 1'b0;
    check("stop_state", {30'd0, bus.state}, 32'd0);
    check("stop_y_valid_e1", {31'd0, bus.y_valid}, 32'd0);
    tick();
    check("stop_y_valid_e2", {31'd0, bus.y_valid}, 32'd1);
    check("stop_y_out", {24'd0, bus.y_out}, 32'd31);
    tick();
    check("hold_y_valid", {31'd0, bus.y_valid}, 32'd0);
    check("hold_y_out", {24'd0, bus.y_out}, 32'd31);

    // Illegal RUN while running
    send_cmd(2'b10);
    for (int i = 0; i < NC - 1; i++) send_beat(8'd1);
    check("err_pre_state", {30'd0, bus.state}, 32'd3);
    check("err_pre_flag", {31'd0, bus.cmd_err}, 32'd0);
    send_cmd(2'b10);
    check("err_state_kept", {30'd0, bus.state}, 32'd3);
    check("err_flag", {31'd0, bus.cmd_err}, {31'd0, ERR_EN});
    send_cmd(2'b11);
    check("err_stop_state", {30'd0, bus.state}, 32'd0);
    check("err_sticky", {31'd0, bus.cmd_err}, {31'd0, ERR_EN});

    // Reset mid-LOAD, beat coinciding with reset is ignored
    send_cmd(2'b01);
    send_beat(8'h09);
    send_beat(8'h0A);
    reset          = 1'b1;
    bus.data_in    = 8'h0B;
    bus.data_valid = 1'b1;
    tick();
    reset          = 1'b0;
    bus.data_valid = 1'b0;
    check("rl_coeffs", bus.coeffs, 32'h04030201);
    check("rl_state", {30'd0, bus.state}, 32'd0);
    check("rl_cmd_err", {31'd0, bus.cmd_err}, 32'd0);
    send_cmd(2'b01);
    ld_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < NC; i++) begin
      send_beat(ld_vals[i]);
      check($sformatf("reload_coeffs_b%0d", i), bus.coeffs,
            (i == NC - 1) ? 32'h44332211 : 32'h04030201);
    end

    // LOAD during PRIME is consumed; reset discards an in-flight result
    send_cmd(2'b10);
    send_cmd(2'b01);
    check("prime_load_ignored", {30'd0, bus.state}, 32'd2);
    for (int i = 0; i < NC - 1; i++) send_beat(8'd1);
    check("rr_state_run", {30'd0, bus.state}, 32'd3);
    send_beat(8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_y_valid", {31'd0, bus.y_valid}, 32'd0);
    check("rr_y_out", {24'd0, bus.y_out}, 32'd0);
    check("rr_state", {30'd0, bus.state}, 32'd0);
    tick();
    check("rr_y_valid_after", {31'd0, bus.y_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_COEFF, default 4, number of FIR taps (>=1).
REQ-002 SHALL have parameter SIZE, default 8, coefficient/sample/result width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 STOP.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-008 SHALL have port data_in  input  SIZE  coefficient (LOAD) or sample (PRIME/RUN).
REQ-009 SHALL have port data_valid  input  1  data_in offered.
REQ-010 SHALL have port data_ready  output  1  beat accepted when data_valid & data_ready.
REQ-011 SHALL have port coeffs  output  NUM_COEFF*SIZE  committed coefficient bus; coeff i at bits [i*SIZE +: SIZE].
REQ-012 SHALL have port sr_en  output  1  shift-register advance strobe.
REQ-013 SHALL have port sr_clear  output  1  one-cycle shift-register clear pulse.
REQ-014 SHALL have port y_in  input  SIZE  combinational filter result.
REQ-015 SHALL have port y_out  output  SIZE  registered result.
REQ-016 SHALL have port y_valid  output  1  one-cycle result strobe.
REQ-017 SHALL have port state  output  2  IDLE=0, LOAD=1, PRIME=2, RUN=3.
REQ-018 SHALL have port cmd_err  output  1  sticky illegal-command flag.

Function
REQ-019 cmd_ready SHALL be 1 in IDLE, PRIME, RUN; 0 in LOAD.
REQ-020 data_ready SHALL be 1 in LOAD, PRIME, RUN; 0 in IDLE.
REQ-021 IDLE: accepted LOAD -> LOAD, beat counter=0; accepted RUN -> PRIME (or RUN directly if NUM_COEFF=1) with sr_clear=1 for that cycle only; NOP/STOP -> stay.
REQ-022 LOAD: each accepted beat writes data_in to shadow[counter], counter+1; beat NUM_COEFF-1 SHALL copy all shadows (incl. that beat) to coeffs at the same edge and return to IDLE.
REQ-023 coeffs SHALL never show a partial set; unchanged until final LOAD beat.
REQ-024 sr_en SHALL equal data_valid & data_ready in PRIME/RUN (combinational), 0 otherwise.
REQ-025 PRIME: count accepted samples; on the (NUM_COEFF-1)th accepted sample -> RUN; no y_valid for PRIME samples.
REQ-026 RUN: sample accepted at edge k SHALL give y_out<=y_in and y_valid=1 after edge k+1 (latency 2 edges), one cycle per sample; back-to-back samples give back-to-back y_valid.
REQ-027 PRIME/RUN: accepted STOP -> IDLE next edge; a sample accepted the same cycle SHALL be shifted and, if in RUN, still produce its y_valid.
REQ-028 PRIME/RUN: accepted LOAD or RUN SHALL be consumed with no state change; IDLE: STOP is a no-op.
REQ-029 y_out SHALL hold its last value when y_valid=0.

Reset
REQ-030 reset=1 at an edge SHALL force: state IDLE, counters 0, coeff i = i+1 (truncated to SIZE), shadows = same, y_out 0, y_valid 0, cmd_err 0, pending result discarded; sr_clear 0.
REQ-031 reset mid-LOAD SHALL discard shadow progress; mid-RUN SHALL discard in-flight result.
REQ-032 reset SHALL take priority over every simultaneous command or data beat.

Configuration
REQ-033 Macro FIR_SEQ_CTRL_CMD_ERR_EN defined: cmd_err sets on accepted LOAD/RUN in PRIME/RUN or STOP in IDLE, clears only by reset.
REQ-034 Macro undefined: cmd_err SHALL be constant 0, no detection logic; all other behaviour identical.

Verification
REQ-035 Reset, no activity -> coeffs=0x04030201, state=0, y_valid=0, cmd_err=0.
REQ-036 LOAD then beats 5,6,7,8 -> coeffs stays 0x04030201 until 4th beat edge, then 0x08070605; state returns 0.
REQ-037 RUN, samples 1,1,1,1,1 with y_in driven by model -> sr_clear one cycle on RUN accept; first 3 samples no y_valid; y_valid on 4th and 5th, each 2 edges after acceptance.
REQ-038 STOP with data_valid same cycle in RUN -> sample shifted, y_valid 2 edges later, state IDLE.
REQ-039 With macro: RUN in RUN state -> cmd_err=1, state unchanged; without macro: cmd_err stays 0.
REQ-040 reset asserted after 2nd LOAD beat -> coeffs default, then fresh 4-beat LOAD commits correctly.
